rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares one resource among 8 requesters. It picks a single winner, holds the grant while the winner keeps its request asserted, and preempts the winner after a programmable hold limit when other requesters are waiting. Internally the winner is tracked as a 3-bit index and decoded to a one-hot 8-bit grant vector. The grant bus drives the select/enable side of the shared datapath.

---
 rtl/rr_arbiter_8.sv | 133 +++++++++++++
 tb/tb_rr_arbiter_8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter sharing one resource among 8 requesters.
//
// A winner is picked in IDLE by scanning upward from the slot after the last
// owner. The grant is held while the owner keeps requesting, and it is revoked
// by a hold limit when other requesters are waiting. Every handover passes
// through one IDLE cycle with no grant.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   req_i[7:0]   level-sensitive request vector, bit i = requester i
//   grant_o[7:0] registered one-hot grant, zero when there is no owner
//   grant_idx_o  index of the current owner, valid only while busy_o = 1
//   busy_o       1 while a grant is active
//   preempt_o    one-cycle pulse in the dead cycle after a hold-limit revoke
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16  // legal range 2..255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] req_i,
    output logic [7:0] grant_o,
    output logic [2:0] grant_idx_o,
    output logic       busy_o,
    output logic       preempt_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] last_q, last_d;
    logic [7:0] grant_q, grant_d;
    logic [7:0] hold_q, hold_d;
    logic       busy_q, busy_d;
    logic       preempt_q, preempt_d;

    logic [2:0] scan_idx;
    logic [2:0] win_idx;
    logic       win_found;
    logic [7:0] hold_inc;
    logic       contended;

    // First requester at or after last_q+1, wrapping 7 -> 0. The eighth probe
    // (offset 8 truncates to 0) lands on last_q itself.
    always_comb begin
        scan_idx  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            scan_idx = last_q + 3'(i);
            if (!win_found && req_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Saturating count including the current cycle; testing the limit on this
    // value makes a contended grant last exactly MAX_HOLD-1 cycles.
    assign hold_inc  = (hold_q >= HoldMax) ? HoldMax : hold_q + 8'd1;
    assign contended = |(req_i & ~grant_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    state_d = StBusy;
                    idx_d   = win_idx;
                    grant_d = 8'd1 << win_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            StBusy: begin
                if (!req_i[idx_q]) begin
                    // Release takes precedence over the hold limit.
                    state_d = StIdle;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    last_d  = idx_q;
                end else if (hold_inc == HoldMax && contended) begin
                    state_d   = StIdle;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    last_d    = idx_q;
                    preempt_d = 1'b1;
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            last_q    <= 3'd7;
            grant_q   <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = busy_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random request traffic,
// all checked against a cycle-level behavioural model of the arbiter.
module tb_rr_arbiter_8;

    localparam int unsigned MaxHold = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] req_i;
    logic [7:0] grant_o;
    logic [2:0] grant_idx_o;
    logic       busy_o;
    logic       preempt_o;

    int checks   = 0;
    int failures = 0;

    // Model state: owner, ownership length in visible grant cycles, last owner.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;
    bit m_preempt;

    rr_arbiter_8 #(.MAX_HOLD(MaxHold)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .grant_o    (grant_o),
        .grant_idx_o(grant_idx_o),
        .busy_o     (busy_o),
        .preempt_o  (preempt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_owner   = 0;
        m_last    = 7;
        m_held    = 0;
        m_preempt = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        bit found;
        if (!m_busy) begin
            m_preempt = 1'b0;
            if (r != 8'd0) begin
                found = 1'b0;
                for (int i = 1; i <= 8; i++) begin
                    int c;
                    c = (m_last + i) % 8;
                    if (!found && r[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                    end
                end
                m_busy = 1'b1;
                m_held = 1;
            end
        end else if (!r[m_owner]) begin
            m_busy    = 1'b0;
            m_last    = m_owner;
            m_preempt = 1'b0;
        end else if (m_held >= int'(MaxHold) - 1 && (r & ~(8'd1 << m_owner)) != 8'd0) begin
            m_busy    = 1'b0;
            m_last    = m_owner;
            m_preempt = 1'b1;
        end else begin
            m_held++;
            m_preempt = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        logic [7:0] exp_grant;
        exp_grant = m_busy ? (8'd1 << m_owner) : 8'd0;
        check_eq({tag, "/grant"}, 32'(grant_o), 32'(exp_grant));
        check_eq({tag, "/busy"}, 32'(busy_o), 32'(m_busy));
        check_eq({tag, "/preempt"}, 32'(preempt_o), 32'(m_preempt));
        if (m_busy) check_eq({tag, "/idx"}, 32'(grant_idx_o), 32'(m_owner));
    endtask

    // Present r for one cycle, advance the model on the edge, check after it.
    task automatic cycle(input logic [7:0] r, input string tag);
        req_i = r;
        @(posedge clk_i);
        if (rst_ni) model_step(r);
        else model_reset();
        #1;
        compare(tag);
    endtask

    initial begin
        logic [7:0] cur;
        int         preempt_seen;

        // Reset held with every requester active.
        rst_ni = 1'b0;
        req_i  = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare("reset");
        check_eq("reset_grant", 32'(grant_o), 32'h00);
        rst_ni = 1'b1;
        cycle(8'hFF, "first");
        check_eq("first_grant", 32'(grant_o), 32'h01);
        check_eq("first_idx", 32'(grant_idx_o), 32'd0);

        // Round robin: each owner drops its bit after 3 grant cycles.
        for (int g = 0; g < 8; g++) begin
            check_eq("rr_seq", 32'(grant_o), 32'(8'd1 << g));
            cycle(8'hFF, "rr_hold");
            cycle(8'hFF, "rr_hold");
            cycle(8'hFF & ~(8'd1 << g), "rr_drop");
            check_eq("rr_dead", 32'(grant_o), 32'h00);
            cycle(8'hFF, "rr_next");
        end
        check_eq("rr_wrap", 32'(grant_o), 32'h01);

        // Wrap scan from last=5 with req=09: ch0 first, then ch3.
        cycle(8'h00, "wrap_rel");
        cycle(8'h20, "wrap_g5");
        cycle(8'h00, "wrap_rel5");
        cycle(8'h09, "wrap_g0");
        check_eq("wrap_ch0", 32'(grant_o), 32'h01);
        cycle(8'h08, "wrap_rel0");
        cycle(8'h08, "wrap_g3");
        check_eq("wrap_ch3", 32'(grant_o), 32'h08);

        // Preemption ping-pong between ch0 and ch1.
        cycle(8'h00, "pre_rel");
        cycle(8'h03, "pre_g0");
        for (int k = 0; k < 3; k++) begin
            check_eq("pre_owner", 32'(grant_o), (k % 2 == 0) ? 32'h01 : 32'h02);
            cycle(8'h03, "pre_hold");
            cycle(8'h03, "pre_hold");
            cycle(8'h03, "pre_fire");
            check_eq("pre_pulse", 32'(preempt_o), 32'd1);
            check_eq("pre_dead", 32'(grant_o), 32'h00);
            cycle(8'h03, "pre_next");
            check_eq("pre_pulse_end", 32'(preempt_o), 32'd0);
        end

        // Uncontended hold, then contention preempts on the next edge.
        cycle(8'h00, "unc_rel");
        cycle(8'h10, "unc_g4");
        preempt_seen = 0;
        for (int k = 0; k < 50; k++) begin
            cycle(8'h10, "unc_hold");
            if (preempt_o) preempt_seen++;
        end
        check_eq("unc_grant", 32'(grant_o), 32'h10);
        check_eq("unc_no_preempt", 32'(preempt_seen), 32'd0);
        cycle(8'h14, "unc_contend");
        check_eq("unc_pulse", 32'(preempt_o), 32'd1);
        cycle(8'h14, "unc_next");
        check_eq("unc_ch2", 32'(grant_o), 32'h04);

        // Asynchronous reset between edges while ch5 owns.
        cycle(8'h00, "ar_rel");
        cycle(8'h20, "ar_g5");
        check_eq("ar_pre", 32'(grant_o), 32'h20);
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_eq("ar_async_grant", 32'(grant_o), 32'h00);
        compare("ar_async");
        @(posedge clk_i);
        #1;
        req_i  = 8'h20;
        rst_ni = 1'b1;
        cycle(8'h20, "ar_regrant");
        check_eq("ar_regrant_ch5", 32'(grant_o), 32'h20);

        // Random traffic: sparse bit flips give long holds and contention.
        cur = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
            end
            if ((n / 500) % 2 == 1) cur = cur & 8'($urandom);
            cycle(cur, "rand");
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_ni = 1'b0;
                model_reset();
                #1;
                compare("rand_rst");
                @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
